bias_loader: RTL

- Serial-to-parallel bias parameter loader that produces the packed SIZE-lane 8-bit bias vector consumed as the bias operand of the per-lane bias adders in a layer.
- Accepts one unsigned 8-bit bias byte per beat over a valid/ready stream into a shadow bank.
- Commits the shadow bank to the active (output) bank on a swap request, so the next layer's biases load while the current layer computes.

---
 rtl/bias_loader_pkg.sv | 16 +
 rtl/bias_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/bias_loader_pkg.sv
// Shared layer definitions for the bias loader: byte width,
// loader state encoding and the lane-index width helper.
package bias_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } ld_state_e;

    function automatic int idx_w(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/bias_loader.sv
// Serial-to-parallel bias loader: bytes fill a shadow bank,
// a swap commits the full shadow bank to the active bias vector.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   swap,
    output logic [BYTE_W*SIZE-1:0] bias_out,
    output logic                   bias_valid,
    output logic                   shadow_full
);

    localparam int            IW   = idx_w(SIZE);
    localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

    ld_state_e                          state_q;
    logic [IW-1:0]                      idx_q;
    logic [SIZE-1:0][BYTE_W-1:0]        shadow_q;
    logic [SIZE-1:0][BYTE_W-1:0]        active_q;
    logic                               bias_valid_q;
    logic                               shadow_full_q;
    logic                               in_ready_q;
    logic                               beat;

    assign beat = in_valid && in_ready_q;

    // Priority: reset, flush, swap (FULL only), accepted beat (FILL only)
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FILL;
            idx_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            bias_valid_q  <= 1'b0;
            shadow_full_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else if (flush) begin
            state_q       <= FILL;
            idx_q         <= '0;
            shadow_full_q <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            unique case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        shadow_q[idx_q] <= in_data;
                        if (idx_q == LAST) begin
                            idx_q         <= '0;
                            state_q       <= FULL;
                            shadow_full_q <= 1'b1;
                            in_ready_q    <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                FULL: begin
                    in_ready_q <= 1'b0;
                    if (swap) begin
                        active_q      <= shadow_q;
                        bias_valid_q  <= 1'b1;
                        shadow_full_q <= 1'b0;
                        state_q       <= FILL;
                        in_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign bias_out    = active_q;
    assign bias_valid  = bias_valid_q;
    assign shadow_full = shadow_full_q;

endmodule
